muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit owning the HI/LO register pair for the multicycle MIPS datapath.
//  Replaces the single-shot combinational multiply with a WIDTH-parametrised shift/add multiplier and restoring divider.
//  Signed and unsigned operation; start/busy/done handshake to the controller FSM.
//  Sits beside the ALU: operands come from the accumulation regs A/B; hi/lo feed the ALU-out mux (mfhi/mflo).
// PARAMETERS
//  WIDTH   32   operand width; hi/lo are WIDTH each; product is 2*WIDTH
// PORTS
//  clk      in   1       single clock, rising edge
//  rst      in   1       synchronous, active-high reset
//  start    in   1       launch op; sampled only in IDLE
//  op       in   2       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  src_a    in   WIDTH   multiplicand / dividend (reg A)
//  src_b    in   WIDTH   multiplier / divisor (reg B)
//  hi_wr    in   1       mthi: hi <= src_a (IDLE only)
//  lo_wr    in   1       mtlo: lo <= src_a (IDLE only)
//  busy     out  1       high from cycle after accepted start until done
//  done     out  1       one-cycle pulse; hi/lo hold the new result in that cycle
//  op_err   out  1       one-cycle pulse with done on error (see below)
//  hi       out  WIDTH   HI register (mult upper half / div remainder)
//  lo       out  WIDTH   LO register (mult lower half / div quotient)
// BEHAVIOUR
//  Reset: state IDLE; hi = lo = 0; busy = done = op_err = 0; iteration counter = 0.
//  FSM: IDLE -> RUN on start. RUN lasts exactly WIDTH cycles, one bit per cycle.
//   RUN -> FIX after WIDTH iterations. FIX applies sign correction and writes hi/lo. FIX -> DONE.
//   DONE pulses done for one cycle, then -> IDLE.
//  Latency: start sampled at edge N -> done high in cycle after edge N+WIDTH+2. Back-to-back start is accepted in the cycle after done.
//  Operands and op are captured at the start edge; later changes on src_a/src_b/op are ignored.
//  Signed ops (MULT, DIV) operate on magnitudes; the result is negated in FIX.
//   Product sign = sign_a ^ sign_b. Quotient sign = sign_a ^ sign_b. Remainder sign = sign_a.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product; no overflow possible.
//  DIV most-negative / -1: lo = 2^(WIDTH-1) (wraps), hi = 0, op_err = 0.
//  Divide by zero: no iterations are skipped (latency unchanged); hi = src_a, lo = all ones; op_err pulses with done.
//  start while busy: ignored (no queueing). hi_wr/lo_wr while busy: ignored; hi/lo are never disturbed mid-op.
//  start + hi_wr/lo_wr in the same IDLE cycle: the write takes effect at that edge and the op result later overwrites it.
//  hi_wr and lo_wr together: both written from src_a.
//  rst mid-operation: abort at the next edge to the reset values above; no done pulse.
//  hi/lo change only on reset, an accepted mthi/mtlo, or the FIX->DONE edge.
// CONFIGURATION
//  MULDIV_DIV_EN defined: full behaviour above, all four ops.
//  MULDIV_DIV_EN undefined: divider datapath not built.
//   DIVU/DIV are accepted as no-ops: busy for one cycle, then done + op_err pulse; hi/lo unchanged.
//   MULT/MULTU behaviour and latency are identical in both builds.
// TESTING (WIDTH=32)
//  MULTU 7 x 6 -> done at start+34, hi=0x00000000, lo=0x0000002A, op_err=0.
//  MULT 0xFFFFFFFD(-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, op_err=1 with done. Without MULDIV_DIV_EN: DIV 9/3 -> done 2 cycles after start, op_err=1, hi/lo unchanged.
//  mtlo 0x1234 in IDLE -> lo=0x1234 next cycle. mthi during busy -> hi unchanged. Second start during busy -> no extra done.
//  rst at start+10 of a MULT -> busy=done=0, hi=lo=0 next cycle; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative shift/add multiplier and restoring divider owning the HI/LO pair.
// Define MULDIV_DIV_EN to build the divider; otherwise DIVU/DIV complete as error no-ops.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    output logic             busy,
    output logic             done,
    output logic             op_err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 neg_q, neg_d;
    logic                 noop_q, noop_d;
    logic                 err_pend_q, err_pend_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod;
`ifdef MULDIV_DIV_EN
    logic                 is_div_q, is_div_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     quo, rem;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
    // opnd holds the multiplicand or divisor magnitude.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        neg_d      = neg_q;
        noop_d     = noop_q;
        err_pend_d = err_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sign_a     = op[0] & src_a[WIDTH-1];
        sign_b     = op[0] & src_b[WIDTH-1];
        mag_a      = sign_a ? -src_a : src_a;
        mag_b      = sign_b ? -src_b : src_b;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        prod       = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        rem_neg_d  = rem_neg_q;
        div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, opnd_q};
        div_diff   = div_shift[WIDTH-1:0] - opnd_q;
        quo        = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];
`endif

        case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = src_a;
                if (lo_wr) lo_d = src_a;
                if (start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    neg_d  = sign_a ^ sign_b;
                    if (op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
`ifdef MULDIV_DIV_EN
                    state_d    = RUN;
                    noop_d     = 1'b0;
                    is_div_d   = op[1];
                    rem_neg_d  = sign_a;
                    err_pend_d = op[1] & (src_b == '0);
`else
                    state_d    = op[1] ? FIX : RUN;
                    noop_d     = op[1];
                    err_pend_d = op[1];
`endif
                end
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q)
                    acc_d = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
                else
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`else
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
`endif
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            FIX: begin
                state_d = DONE;
                busy_d  = ~noop_q;
                if (!noop_q) begin
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        lo_d = err_pend_q ? '1 : (neg_q ? -quo : quo);
                        hi_d = rem_neg_q ? -rem : rem;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
`else
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = err_pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_q      <= 1'b0;
            noop_q     <= 1'b0;
            err_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            neg_q      <= neg_d;
            noop_q     <= noop_d;
            err_pend_q <= err_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef MULDIV_DIV_EN
            is_div_q   <= is_div_d;
            rem_neg_q  <= rem_neg_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign op_err = err_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): spec vectors, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_wr;
    logic        lo_wr;
    logic        busy;
    logic        done;
    logic        op_err;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .busy   (busy),
        .done   (done),
        .op_err (op_err),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected results from plain integer arithmetic on the architectural rules.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                     output logic [31:0] rh, output logic [31:0] rl,
                                     output logic re, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        re  = 1'b0;
        lat = 34;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        rh  = cur_hi;
        rl  = cur_lo;
        if (o == 2'b00) begin
            p = {32'd0, a} * {32'd0, b};
            rh = p[63:32]; rl = p[31:0];
        end else if (o == 2'b01) begin
            p = sa * sb;
            rh = p[63:32]; rl = p[31:0];
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
                rh = a; rl = 32'hFFFF_FFFF; re = 1'b1;
            end else if (o == 2'b10) begin
                rl = a / b; rh = a % b;
            end else begin
                q = sa / sb; r = sa % sb;
                rl = q[31:0]; rh = r[31:0];
            end
`else
            re = 1'b1;
            lat = 2;
`endif
        end
    endfunction

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el, input logic ee,
                                 input int lat, input int disturb, input logic wr_with_start,
                                 input string name);
        int k;
        int extra;
        logic got;
        logic [31:0] pre_hi, pre_lo;
        pre_hi = m_hi;
        pre_lo = wr_with_start ? a : m_lo;
        op = o; src_a = a; src_b = b; start = 1'b1; lo_wr = wr_with_start;
        tick();
        start = 1'b0; lo_wr = 1'b0;
        if (wr_with_start) checkOutput({name, "_lo_wr_at_start"}, lo, a);
        checkOutput({name, "_busy"}, busy, 1);
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
        k = 0;
        got = 1'b0;
        while (!got && k < 100) begin
            if (disturb != 0 && k == disturb) begin
                start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1;
            end
            tick();
            k++;
            if (disturb != 0 && k == disturb + 1) begin
                start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
                checkOutput({name, "_hi_held"}, hi, pre_hi);
                checkOutput({name, "_lo_held"}, lo, pre_lo);
            end
            if (done) got = 1'b1;
        end
        checkOutput({name, "_latency"}, k, lat);
        checkOutput({name, "_hi"}, hi, eh);
        checkOutput({name, "_lo"}, lo, el);
        checkOutput({name, "_err"}, op_err, ee);
        tick();
        checkOutput({name, "_done_pulse"}, done, 0);
        if (disturb != 0) begin
            extra = 0;
            repeat (40) begin
                tick();
                if (done) extra++;
            end
            checkOutput({name, "_no_extra_done"}, extra, 0);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic        ee;
        logic [1:0]  o;
        int          lat, sel;

        tbl[0] = '{2'b00, 32'd7,          32'd6,          32'h0000_0000, 32'h0000_002A, 1'b0};
        tbl[1] = '{2'b01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[3] = '{2'b10, 32'd100,        32'd7,          32'd2,         32'd14,        1'b0};
        tbl[4] = '{2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[5] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[6] = '{2'b10, 32'd5,          32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1};
        tbl[7] = '{2'b11, 32'd9,          32'd3,          32'd0,         32'd3,         1'b0};
        tbl[8] = '{2'b01, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[9] = '{2'b01, 32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; hi_wr = 1'b0; lo_wr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", op_err, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);

        src_a = 32'h0000_1234; lo_wr = 1'b1;
        tick();
        lo_wr = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h0000_1234);
        checkOutput("mtlo_hi_kept", hi, 0);
        m_lo = 32'h0000_1234;
        src_a = 32'hCAFE_F00D; hi_wr = 1'b1; lo_wr = 1'b1;
        tick();
        hi_wr = 1'b0; lo_wr = 1'b0;
        checkOutput("mthi_mtlo_hi", hi, 32'hCAFE_F00D);
        checkOutput("mthi_mtlo_lo", lo, 32'hCAFE_F00D);
        m_hi = 32'hCAFE_F00D;
        m_lo = 32'hCAFE_F00D;

        for (int i = 0; i < NV; i++) begin
            eh = tbl[i].hi; el = tbl[i].lo; ee = tbl[i].err; lat = 34;
`ifndef MULDIV_DIV_EN
            if (tbl[i].op[1]) begin
                eh = m_hi; el = m_lo; ee = 1'b1; lat = 2;
            end
`endif
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, eh, el, ee, lat, 0, 1'b0,
                          $sformatf("vec%0d", i));
        end

        applyStimulus(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 34, 5, 1'b0, "busy_disturb");
        applyStimulus(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 34, 0,
                      1'b1, "start_with_mtlo");

        op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h8765_4321; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        applyStimulus(2'b00, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 34, 0, 1'b0, "after_abort");

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            refModel(o, a, b, m_hi, m_lo, eh, el, ee, lat);
            applyStimulus(o, a, b, eh, el, ee, lat, 0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
